// File: rtl/pipe_latency_tracker.sv
// Tracks read / butterfly / write pipeline latency, outstanding beats and stage completion.
// Define TRACKER_ERR_EN to build the sticky overflow/underflow error flags.
module pipe_latency_tracker #(
  parameter int unsigned RD_LAT          = 2,
  parameter int unsigned BU_LAT          = 8,
  parameter int unsigned WR_LAT          = 1,
  parameter int unsigned MAX_INFLIGHT    = 16,
  parameter int unsigned BEATS_PER_STAGE = 16,
  localparam int unsigned D_WIDTH        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               r_enable,
  input  logic               ntt_enable,
  input  logic               w_enable,
  input  logic               flush,
  output logic               r_enable_out,
  output logic               ntt_done,
  output logic               w_enable_out,
  output logic [D_WIDTH-1:0] inflight,
  output logic               pipe_empty,
  output logic               drain_done,
  output logic               stage_done,
  output logic               err_overflow,
  output logic               err_underflow
);

  localparam int unsigned CNT_W = (BEATS_PER_STAGE > 1) ? $clog2(BEATS_PER_STAGE) : 1;
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS_PER_STAGE - 1);
  localparam logic [D_WIDTH-1:0] MAX_CNT   = D_WIDTH'(MAX_INFLIGHT);

  logic [RD_LAT-1:0]  rd_line;
  logic [BU_LAT-1:0]  bu_line;
  logic [WR_LAT-1:0]  wr_line;
  logic [D_WIDTH-1:0] inflight_q;
  logic [D_WIDTH-1:0] inflight_d;
  logic [CNT_W-1:0]   beat_cnt;
  logic               was_busy;
  logic               stage_wrap;

  // Shift lines: bit 0 takes the new beat, the MSB is the delayed output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_line <= '0;
      bu_line <= '0;
      wr_line <= '0;
    end else if (flush) begin
      rd_line <= '0;
      bu_line <= '0;
      wr_line <= '0;
    end else begin
      rd_line <= (rd_line << 1) | RD_LAT'(r_enable);
      bu_line <= (bu_line << 1) | BU_LAT'(ntt_enable);
      wr_line <= (wr_line << 1) | WR_LAT'(w_enable);
    end
  end

  assign r_enable_out = rd_line[RD_LAT-1];
  assign ntt_done     = bu_line[BU_LAT-1];
  assign w_enable_out = wr_line[WR_LAT-1];

  always_comb begin
    inflight_d = inflight_q;
    if (r_enable && !w_enable_out && inflight_q != MAX_CNT)
      inflight_d = inflight_q + D_WIDTH'(1);
    else if (!r_enable && w_enable_out && inflight_q != '0)
      inflight_d = inflight_q - D_WIDTH'(1);
  end

  assign stage_wrap = w_enable_out && (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      beat_cnt   <= '0;
      was_busy   <= 1'b0;
    end else if (flush) begin
      inflight_q <= '0;
      beat_cnt   <= '0;
      was_busy   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      was_busy   <= !pipe_empty;
      if (w_enable_out)
        beat_cnt <= stage_wrap ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  assign inflight   = inflight_q;
  assign pipe_empty = (inflight_q == '0) && (rd_line == '0) && (bu_line == '0) && (wr_line == '0);
  // was_busy is cleared by flush/reset so neither can produce a drain pulse.
  assign drain_done = pipe_empty && was_busy;
  assign stage_done = stage_wrap;

`ifdef TRACKER_ERR_EN
  logic err_ovf_q;
  logic err_unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else if (flush) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      if (r_enable && inflight_q == MAX_CNT)
        err_ovf_q <= 1'b1;
      if (w_enable_out && inflight_q == '0)
        err_unf_q <= 1'b1;
    end
  end

  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule
